// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and external-pin signals of the multiplexed memory bus arbiter.
// slave: the arbiter's view; master: the requesters and bus pins driving it.
interface mem_bus_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 20,
  parameter int DW  = 16
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    rw;
  logic [NCH-1:0]    io;
  logic [NCH*AW-1:0] adr;
  logic [NCH*DW-1:0] dtw;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     dtr;
  logic [DW-1:0]     din;
  logic [DW-1:0]     dout;
  logic              isout;
  logic [AW-17:0]    adr_hi;
  logic              ale_neg;
  logic              oe;
  logic              we;
  logic              pio;

  modport slave (
    input  req, rw, io, adr, dtw, din,
    output ack, dtr, dout, isout, adr_hi, ale_neg, oe, we, pio
  );

  modport master (
    output req, rw, io, adr, dtw, din,
    input  ack, dtr, dout, isout, adr_hi, ale_neg, oe, we, pio
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates NCH requesters onto one multiplexed address/data bus and runs the full bus cycle.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, channel 0 highest.
module mem_bus_arbiter #(
  parameter int NCH  = 2,
  parameter int AW   = 20,
  parameter int DW   = 16,
  parameter int WAIT = 1
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, TURN, DATA, ACK} state_t;

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         state, state_nxt;
  logic [3:0]     wcnt;
  logic [IW-1:0]  gnt, gnt_q;
  logic           gnt_vld;
  logic [DW-1:0]  dtw_q;
  logic           rw_q;

  logic [AW-1:0]  adr_sel;
  logic [DW-1:0]  dtw_sel;
  logic           rw_sel;
  logic           io_sel;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] ptr;

  // Scan downward from ptr+NCH-1 so the channel nearest the pointer is the last (winning) hit.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NCH;
      if (bus.req[idx]) begin
        gnt     = IW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == IDLE && gnt_vld) begin
      ptr <= (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_vld = |bus.req;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.req[k]) gnt = IW'(k);
    end
  end
`endif

  // Granted channel's inputs, only meaningful while leaving IDLE.
  always_comb begin
    adr_sel = bus.adr[int'(gnt) * AW +: AW];
    dtw_sel = bus.dtw[int'(gnt) * DW +: DW];
    rw_sel  = bus.rw[gnt];
    io_sel  = bus.io[gnt];
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ADDR;
      ADDR:    state_nxt = rw_q ? TURN : DATA;
      TURN:    state_nxt = DATA;
      DATA:    if (wcnt == 4'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      gnt_q <= '0;
      dtw_q <= '0;
      rw_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gnt_vld) begin
        gnt_q <= gnt;
        dtw_q <= dtw_sel;
        rw_q  <= rw_sel;
      end
      if (state_nxt == DATA && state != DATA) wcnt <= 4'(WAIT);
      else if (state == DATA && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
    end
  end

  // Outputs are registered from the state being entered, so they line up with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack     <= '0;
      bus.dtr     <= '0;
      bus.dout    <= '0;
      bus.isout   <= 1'b0;
      bus.adr_hi  <= '0;
      bus.ale_neg <= 1'b1;
      bus.oe      <= 1'b0;
      bus.we      <= 1'b0;
      bus.pio     <= 1'b0;
    end else begin
      case (state_nxt)
        IDLE: begin
          bus.ack     <= '0;
          bus.dout    <= '0;
          bus.isout   <= 1'b0;
          bus.adr_hi  <= '0;
          bus.ale_neg <= 1'b1;
          bus.oe      <= 1'b0;
          bus.we      <= 1'b0;
          bus.pio     <= 1'b0;
        end
        ADDR: begin
          bus.ack     <= '0;
          bus.dout    <= adr_sel[15:0];
          bus.isout   <= 1'b1;
          bus.adr_hi  <= adr_sel[AW-1:16];
          bus.ale_neg <= 1'b0;
          bus.oe      <= 1'b0;
          bus.we      <= 1'b0;
          bus.pio     <= io_sel;
        end
        TURN: begin
          bus.isout   <= 1'b0;
          bus.ale_neg <= 1'b1;
          bus.oe      <= 1'b0;
        end
        DATA: begin
          bus.ale_neg <= 1'b1;
          if (rw_q) begin
            bus.isout <= 1'b0;
            bus.oe    <= 1'b1;
          end else begin
            bus.isout <= 1'b1;
            bus.dout  <= dtw_q;
            bus.we    <= 1'b1;
          end
        end
        ACK: begin
          bus.ack <= NCH'(1) << gnt_q;
          bus.oe  <= 1'b0;
          bus.we  <= 1'b0;
          if (rw_q) bus.isout <= 1'b0;
        end
        default: begin
          bus.ack <= '0;
        end
      endcase
      if (state == DATA && state_nxt == ACK && rw_q) bus.dtr <= bus.din;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus contention,
// reset and wait-state corner sequences. Honours MEM_ARB_RR_EN for the grant-order check.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 20;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst;
  always #31 clk = ~clk;

  mem_bus_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus   ();
  mem_bus_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bw0   ();
  mem_bus_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bw15  ();

  mem_bus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(1))  dut     (.clk(clk), .rst(rst), .bus(bus));
  mem_bus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(0))  dut_w0  (.clk(clk), .rst(rst), .bus(bw0));
  mem_bus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(15)) dut_w15 (.clk(clk), .rst(rst), .bus(bw15));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ch;
    bit          rw;
    bit          io;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    bit          drop_early;
    int          exp_lat;
    logic [1:0]  exp_ack;
    logic [15:0] exp_dtr;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  vec_t vecs[7];

  // One complete transaction on the WAIT=1 instance, observed cycle by cycle #1 after each edge.
  task automatic run_txn(input int id, input vec_t v);
    int          lat = 0, n_ale = 0, n_oe = 0, n_we = 0, n_bad_tail = 0;
    logic [15:0] ale_dout = '0;
    logic [3:0]  ale_hi = '0;
    logic        ale_isout = 1'b0, ack_isout = 1'b0;
    logic [1:0]  ack_v = '0;
    bit          pio_ok = 1, wdout_ok = 1, turn_ok = 1;
    string       tag;
    tag = $sformatf("vec%0d", id);
    @(negedge clk);
    bus.rw[v.ch]             = v.rw;
    bus.io[v.ch]             = v.io;
    bus.adr[v.ch*AW +: AW]   = v.addr;
    bus.dtw[v.ch*DW +: DW]   = v.wdata;
    bus.din                  = v.din;
    bus.req[v.ch]            = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (v.drop_early && c == 1) bus.req[v.ch] = 1'b0;
      if (!bus.ale_neg) begin
        n_ale++;
        ale_dout  = bus.dout;
        ale_hi    = bus.adr_hi;
        ale_isout = bus.isout;
      end
      if (bus.oe) n_oe++;
      if (bus.we) begin
        n_we++;
        if (bus.dout !== v.wdata || bus.isout !== 1'b1) wdout_ok = 0;
      end
      if (bus.pio !== v.io) pio_ok = 0;
      if (c == 2 && v.rw && (bus.isout || !bus.ale_neg || bus.oe)) turn_ok = 0;
      if (bus.ack != '0) begin
        lat       = c;
        ack_v     = bus.ack;
        ack_isout = bus.isout;
        bus.req[v.ch] = 1'b0;
      end
    end
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " ack"}, ack_v, v.exp_ack);
    check({tag, " dtr"}, bus.dtr, v.exp_dtr);
    check({tag, " ale cycles"}, n_ale, 1);
    check({tag, " ale dout"}, ale_dout, v.addr[15:0]);
    check({tag, " ale adr_hi"}, ale_hi, v.addr[19:16]);
    check({tag, " ale isout"}, ale_isout, 1);
    check({tag, " oe cycles"}, n_oe, v.exp_oe);
    check({tag, " we cycles"}, n_we, v.exp_we);
    check({tag, " write dout"}, wdout_ok, 1);
    check({tag, " pio"}, pio_ok, 1);
    check({tag, " ack isout"}, ack_isout, !v.rw);
    if (v.rw) check({tag, " turn"}, turn_ok, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.ack != '0 || !bus.ale_neg || bus.isout || bus.oe || bus.we) n_bad_tail++;
    end
    check({tag, " idle after ack"}, n_bad_tail, 0);
    check({tag, " dtr held"}, bus.dtr, v.exp_dtr);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] got[4];
    logic [1:0] exp_order[4];
    int n_ack, lat0, lat15, oe0, oe15;

    bus.req = '0;  bus.rw = '0;  bus.io = '0;  bus.adr = '0;  bus.dtw = '0;  bus.din = '0;
    bw0.req = '0;  bw0.rw = '0;  bw0.io = '0;  bw0.adr = '0;  bw0.dtw = '0;  bw0.din = '0;
    bw15.req = '0; bw15.rw = '0; bw15.io = '0; bw15.adr = '0; bw15.dtw = '0; bw15.din = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack", bus.ack, 0);
    check("reset dtr", bus.dtr, 0);
    check("reset dout", bus.dout, 0);
    check("reset isout", bus.isout, 0);
    check("reset adr_hi", bus.adr_hi, 0);
    check("reset ale_neg", bus.ale_neg, 1);
    check("reset oe/we/pio", {bus.oe, bus.we, bus.pio}, 0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{ch:0, rw:1, io:0, addr:20'hA1234, wdata:16'h0000, din:16'hBEEF, drop_early:0,
                exp_lat:5, exp_ack:2'b01, exp_dtr:16'hBEEF, exp_oe:2, exp_we:0};
    vecs[1] = '{ch:1, rw:0, io:1, addr:20'h00010, wdata:16'h55AA, din:16'h0000, drop_early:0,
                exp_lat:4, exp_ack:2'b10, exp_dtr:16'hBEEF, exp_oe:0, exp_we:2};
    vecs[2] = '{ch:1, rw:1, io:0, addr:20'h3FFFF, wdata:16'h0000, din:16'h0001, drop_early:0,
                exp_lat:5, exp_ack:2'b10, exp_dtr:16'h0001, exp_oe:2, exp_we:0};
    vecs[3] = '{ch:0, rw:0, io:0, addr:20'hFFFFF, wdata:16'hFFFF, din:16'hABCD, drop_early:0,
                exp_lat:4, exp_ack:2'b01, exp_dtr:16'h0001, exp_oe:0, exp_we:2};
    vecs[4] = '{ch:0, rw:1, io:1, addr:20'h00000, wdata:16'h0000, din:16'h8000, drop_early:0,
                exp_lat:5, exp_ack:2'b01, exp_dtr:16'h8000, exp_oe:2, exp_we:0};
    vecs[5] = '{ch:0, rw:1, io:0, addr:20'h5A5A5, wdata:16'h0000, din:16'h1111, drop_early:1,
                exp_lat:5, exp_ack:2'b01, exp_dtr:16'h1111, exp_oe:2, exp_we:0};
    vecs[6] = '{ch:1, rw:1, io:0, addr:20'h7C0DE, wdata:16'h0000, din:16'h2468, drop_early:0,
                exp_lat:5, exp_ack:2'b10, exp_dtr:16'h2468, exp_oe:2, exp_we:0};

    for (int i = 0; i < 6; i++) run_txn(i, vecs[i]);

    // Both channels hold req continuously across four transactions.
    pulse_reset();
`ifdef MEM_ARB_RR_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    got = '{default: 2'b00};
    n_ack = 0;
    @(negedge clk);
    bus.rw = 2'b00;
    bus.io = 2'b00;
    bus.adr = {20'h22222, 20'h11111};
    bus.dtw = {16'h2222, 16'h1111};
    bus.req = 2'b11;
    for (int c = 0; c < 60 && n_ack < 4; c++) begin
      @(posedge clk); #1;
      if (bus.ack != '0) begin
        got[n_ack] = bus.ack;
        n_ack++;
        if (n_ack == 4) bus.req = 2'b00;
      end
    end
    bus.req = 2'b00;
    for (int i = 0; i < 4; i++) check($sformatf("held contention grant %0d", i), got[i], exp_order[i]);
    repeat (3) @(posedge clk);

    // Both request together; each drops on its own ack: ch0 then ch1, then silence.
    got = '{default: 2'b00};
    n_ack = 0;
    @(negedge clk);
    bus.req = 2'b11;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.ack != '0) begin
        if (n_ack < 4) got[n_ack] = bus.ack;
        n_ack++;
        bus.req = bus.req & ~bus.ack;
      end
    end
    check("drop-on-ack first", got[0], 2'b01);
    check("drop-on-ack second", got[1], 2'b10);
    check("drop-on-ack count", n_ack, 2);

    // Reset asserted during the second DATA cycle of a write.
    @(negedge clk);
    bus.rw[0] = 1'b0;
    bus.dtw[15:0] = 16'h1357;
    bus.req[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid-data we before reset", bus.we, 1);
    #2;
    rst = 1'b1;
    bus.req = 2'b00;
    #1;
    check("async reset we", bus.we, 0);
    check("async reset isout", bus.isout, 0);
    check("async reset ack/dout", {bus.ack, bus.dout}, 0);
    @(negedge clk);
    rst = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.ack != '0) n_ack++;
    end
    check("no ack after reset", n_ack, 0);
    run_txn(6, vecs[6]);

    // WAIT=0 and WAIT=15 reads run side by side on their own instances.
    lat0 = 0; lat15 = 0; oe0 = 0; oe15 = 0;
    @(negedge clk);
    bw0.rw[0] = 1'b1;  bw0.adr[19:0] = 20'h12345;  bw0.din = 16'h0F0F;  bw0.req[0] = 1'b1;
    bw15.rw[0] = 1'b1; bw15.adr[19:0] = 20'h12345; bw15.din = 16'h0F0F; bw15.req[0] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bw0.oe) oe0++;
      if (bw15.oe) oe15++;
      if (bw0.ack != '0 && lat0 == 0) begin
        lat0 = c;
        bw0.req = '0;
      end
      if (bw15.ack != '0 && lat15 == 0) begin
        lat15 = c;
        bw15.req = '0;
      end
    end
    check("wait0 latency", lat0, 4);
    check("wait0 oe cycles", oe0, 1);
    check("wait0 dtr", bw0.dtr, 16'h0F0F);
    check("wait15 latency", lat15, 19);
    check("wait15 oe cycles", oe15, 16);
    check("wait15 dtr", bw15.dtr, 16'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
